// File: rtl/commit_monitor.sv
// Retire-order tracker and sticky halt detector for an N-wide in-order retire stage.
// Halt causes: magic write to x1, a run of committed self-loops, or a no-commit watchdog.

module commit_lane #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] HALT_MAGIC = 32'h600d600d
) (
    input  logic            load_regfile,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_wdata,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    output logic            magic,
    output logic            self_loop
);
    assign magic     = load_regfile && (rd_addr == 5'd1) && (rd_wdata == HALT_MAGIC);
    assign self_loop = (pc_next == pc);
endmodule

module commit_monitor #(
    parameter int LANES       = 2,
    parameter int XLEN        = 32,
    parameter int ORDER_W     = 64,
    parameter logic [XLEN-1:0] HALT_MAGIC = 32'h600d600d,
    parameter int LOOP_THRESH = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [LANES-1:0]         commit_valid,
    input  logic [LANES*XLEN-1:0]    commit_pc,
    input  logic [LANES*XLEN-1:0]    commit_pc_next,
    input  logic [LANES-1:0]         commit_load_regfile,
    input  logic [LANES*5-1:0]       commit_rd_addr,
    input  logic [LANES*XLEN-1:0]    commit_rd_wdata,
    output logic [LANES*ORDER_W-1:0] lane_order,
    output logic [ORDER_W-1:0]       total_commits,
    output logic                     halt,
    output logic [1:0]               halt_cause,
    output logic                     order_err
);
    localparam int LW      = $clog2(LOOP_THRESH + 1);
    localparam int IW      = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam int WD_LAST = (WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0;

    typedef enum logic {RUN, HALTED} state_t;

    state_t             state, state_nxt;
    logic [LW-1:0]      loop_cnt, loop_nxt;
    logic [IW-1:0]      idle_cnt;
    logic [ORDER_W-1:0] commit_cnt;
    logic [LANES-1:0]   lane_magic, lane_self;
    logic               gap, magic_hit, loop_hit, wdog_hit, any_valid;
    logic [1:0]         cause_nxt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        commit_lane #(.XLEN(XLEN), .HALT_MAGIC(HALT_MAGIC)) u_lane (
            .load_regfile (commit_load_regfile[i]),
            .rd_addr      (commit_rd_addr[i*5 +: 5]),
            .rd_wdata     (commit_rd_wdata[i*XLEN +: XLEN]),
            .pc           (commit_pc[i*XLEN +: XLEN]),
            .pc_next      (commit_pc_next[i*XLEN +: XLEN]),
            .magic        (lane_magic[i]),
            .self_loop    (lane_self[i])
        );
    end

    // Orders, contiguity and loop run are all walked oldest-lane first.
    always_comb begin
        commit_cnt = '0;
        lane_order = '0;
        gap        = 1'b0;
        loop_nxt   = loop_cnt;
        loop_hit   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_order[i*ORDER_W +: ORDER_W] = total_commits + commit_cnt;
            if (commit_valid[i]) begin
                commit_cnt = commit_cnt + ORDER_W'(1);
                if (i > 0 && !commit_valid[(i > 0) ? i-1 : 0]) gap = 1'b1;
                if (lane_self[i]) begin
                    if (loop_nxt != LW'(LOOP_THRESH)) loop_nxt = loop_nxt + LW'(1);
                end else begin
                    loop_nxt = '0;
                end
                if (loop_nxt == LW'(LOOP_THRESH)) loop_hit = 1'b1;
            end
        end
        any_valid = |commit_valid;
        magic_hit = |(commit_valid & lane_magic);
        wdog_hit  = (WDOG_CYCLES != 0) && !any_valid && (idle_cnt == IW'(WD_LAST));
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = 2'd0;
        if (magic_hit)     cause_nxt = 2'd1;
        else if (loop_hit) cause_nxt = 2'd2;
        else if (wdog_hit) cause_nxt = 2'd3;
        case (state)
            RUN:     if (cause_nxt != 2'd0) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            total_commits <= '0;
            loop_cnt      <= '0;
            idle_cnt      <= '0;
            halt_cause    <= 2'd0;
            order_err     <= 1'b0;
        end else if (clear) begin
            state         <= RUN;
            total_commits <= '0;
            loop_cnt      <= '0;
            idle_cnt      <= '0;
            halt_cause    <= 2'd0;
            order_err     <= 1'b0;
        end else if (state == RUN) begin
            state         <= state_nxt;
            total_commits <= total_commits + commit_cnt;
            loop_cnt      <= loop_nxt;
            if (any_valid)            idle_cnt <= '0;
            else if (idle_cnt != '1)  idle_cnt <= idle_cnt + IW'(1);
            if (gap)                  order_err <= 1'b1;
            if (state_nxt == HALTED)  halt_cause <= cause_nxt;
        end
    end

    assign halt = (state == HALTED);
endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor: directed stimulus queues expectations, a negedge monitor checks them.

module tb_commit_monitor;
    logic         clk = 0;
    logic         rst = 0;
    logic         clear = 0;
    logic [1:0]   commit_valid = 0;
    logic [63:0]  commit_pc = 0, commit_pc_next = 0, commit_rd_wdata = 0;
    logic [1:0]   commit_load_regfile = 0;
    logic [9:0]   commit_rd_addr = 0;
    logic [127:0] lane_order, lane_order0;
    logic [63:0]  total_commits, total_commits0;
    logic         halt, halt0, order_err, order_err0;
    logic [1:0]   halt_cause, halt_cause0;

    commit_monitor #(.LANES(2), .XLEN(32), .ORDER_W(64), .LOOP_THRESH(4), .WDOG_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
        .commit_load_regfile(commit_load_regfile), .commit_rd_addr(commit_rd_addr),
        .commit_rd_wdata(commit_rd_wdata), .lane_order(lane_order),
        .total_commits(total_commits), .halt(halt), .halt_cause(halt_cause),
        .order_err(order_err));

    commit_monitor #(.LANES(2), .XLEN(32), .ORDER_W(64), .LOOP_THRESH(4), .WDOG_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
        .commit_load_regfile(commit_load_regfile), .commit_rd_addr(commit_rd_addr),
        .commit_rd_wdata(commit_rd_wdata), .lane_order(lane_order0),
        .total_commits(total_commits0), .halt(halt0), .halt_cause(halt_cause0),
        .order_err(order_err0));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_st;
        logic [63:0] tot;
        logic        hlt;
        logic [1:0]  cause;
        logic        oerr;
        bit          chk_ord;
        logic [63:0] o0, o1;
        bit          chk_h0;
        logic        h0;
    } exp_t;

    exp_t q[$];
    int errors = 0, checks = 0;

    function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                chk({e.name, "_stale"}, 64'(cyc), 64'(e.cyc));
            end else begin
                if (e.chk_st) begin
                    chk({e.name, "_total"}, total_commits, e.tot);
                    chk({e.name, "_halt"}, 64'(halt), 64'(e.hlt));
                    chk({e.name, "_cause"}, 64'(halt_cause), 64'(e.cause));
                    chk({e.name, "_oerr"}, 64'(order_err), 64'(e.oerr));
                end
                if (e.chk_ord) begin
                    chk({e.name, "_ord0"}, lane_order[63:0], e.o0);
                    chk({e.name, "_ord1"}, lane_order[127:64], e.o1);
                end
                if (e.chk_h0) chk({e.name, "_wd0_halt"}, 64'(halt0), 64'(e.h0));
            end
        end
    end

    task automatic exp_st(string n, logic [63:0] tot, logic h, logic [1:0] c, logic oe);
        exp_t e;
        e = '{cyc: cyc, name: n, chk_st: 1, tot: tot, hlt: h, cause: c, oerr: oe,
              chk_ord: 0, o0: 0, o1: 0, chk_h0: 0, h0: 0};
        q.push_back(e);
    endtask

    task automatic exp_ord(string n, logic [63:0] o0, logic [63:0] o1);
        exp_t e;
        e = '{cyc: cyc, name: n, chk_st: 0, tot: 0, hlt: 0, cause: 0, oerr: 0,
              chk_ord: 1, o0: o0, o1: o1, chk_h0: 0, h0: 0};
        q.push_back(e);
    endtask

    task automatic exp_h0(string n, logic h);
        exp_t e;
        e = '{cyc: cyc, name: n, chk_st: 0, tot: 0, hlt: 0, cause: 0, oerr: 0,
              chk_ord: 0, o0: 0, o1: 0, chk_h0: 1, h0: h};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(int l, logic [31:0] pc, logic [31:0] pcn, logic ld,
                            logic [4:0] rd, logic [31:0] wd);
        commit_pc[l*32 +: 32]       = pc;
        commit_pc_next[l*32 +: 32]  = pcn;
        commit_load_regfile[l]      = ld;
        commit_rd_addr[l*5 +: 5]    = rd;
        commit_rd_wdata[l*32 +: 32] = wd;
    endtask

    task automatic plain_lanes();
        set_lane(0, 32'h100, 32'h104, 1'b0, 5'd0, 32'h0);
        set_lane(1, 32'h104, 32'h108, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_clear();
        commit_valid = 2'b00;
        clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic run(logic [1:0] v, int n);
        commit_valid = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        plain_lanes();
        tick(); tick();
        exp_st("in_reset", 0, 0, 0, 0);
        rst = 1;
        tick();
        exp_st("after_reset", 0, 0, 0, 0);

        // order and count: 5 x 2'b11 then 1 x 2'b01
        commit_valid = 2'b11;
        exp_ord("ord_first", 0, 1);
        run(2'b11, 3);
        exp_ord("ord_mid", 6, 7);
        run(2'b11, 2);
        commit_valid = 2'b01;
        exp_ord("ord_last", 10, 11);
        tick();
        commit_valid = 2'b00;
        exp_st("count11", 11, 0, 0, 0);
        do_clear();
        exp_st("cleared", 0, 0, 0, 0);

        // magic halt on lane 1 at total 20
        run(2'b11, 10);
        exp_st("pre_magic", 20, 0, 0, 0);
        set_lane(1, 32'h104, 32'h108, 1'b1, 5'd1, 32'h600d600d);
        commit_valid = 2'b11;
        exp_ord("ord_magic", 20, 21);
        tick();
        exp_st("magic_halt", 22, 1, 1, 0);
        plain_lanes();
        run(2'b11, 2);
        exp_st("magic_frozen", 22, 1, 1, 0);
        do_clear();

        // loop halt: both lanes self-loop for two cycles
        set_lane(0, 32'h60, 32'h60, 1'b0, 5'd0, 32'h0);
        set_lane(1, 32'h60, 32'h60, 1'b0, 5'd0, 32'h0);
        run(2'b11, 1);
        exp_st("loop_c1", 2, 0, 0, 0);
        run(2'b11, 1);
        exp_st("loop_halt", 4, 1, 2, 0);
        do_clear();

        // broken run: lane 0 of cycle 2 is not a loop, count ends at 1
        run(2'b11, 1);
        set_lane(0, 32'h5c, 32'h60, 1'b0, 5'd0, 32'h0);
        run(2'b11, 1);
        exp_st("loop_broken", 4, 0, 0, 0);
        set_lane(0, 32'h60, 32'h60, 1'b0, 5'd0, 32'h0);
        run(2'b11, 1);
        exp_st("loop_cnt3", 6, 0, 0, 0);
        run(2'b01, 1);
        exp_st("loop_carry", 7, 1, 2, 0);
        do_clear();

        // watchdog (WDOG_CYCLES=8) on dut, disabled on dut0
        plain_lanes();
        run(2'b00, 7);
        exp_st("wd_7idle", 0, 0, 0, 0);
        run(2'b01, 1);
        run(2'b00, 7);
        exp_st("wd_7idle_b", 1, 0, 0, 0);
        run(2'b00, 1);
        exp_st("wd_halt", 1, 1, 3, 0);
        exp_h0("wd0_early", 0);
        do_clear();
        run(2'b00, 100);
        exp_h0("wd0_100idle", 0);
        exp_st("wd_100idle", 0, 1, 3, 0);
        do_clear();

        // contiguity error
        run(2'b10, 1);
        exp_st("gap", 1, 0, 0, 1);
        run(2'b01, 1);
        exp_st("gap_sticky", 2, 0, 0, 1);
        do_clear();
        exp_st("gap_cleared", 0, 0, 0, 0);

        // async reset while halted at 50
        run(2'b11, 24);
        set_lane(1, 32'h104, 32'h108, 1'b1, 5'd1, 32'h600d600d);
        run(2'b11, 1);
        plain_lanes();
        commit_valid = 2'b00;
        exp_st("halted50", 50, 1, 1, 0);
        tick();
        #1 rst = 0;
        exp_st("async_rst", 0, 0, 0, 0);
        tick();
        rst = 1;
        tick();

        // clear together with magic write
        set_lane(1, 32'h104, 32'h108, 1'b1, 5'd1, 32'h600d600d);
        commit_valid = 2'b11;
        clear = 1;
        tick();
        clear = 0;
        commit_valid = 2'b00;
        plain_lanes();
        exp_st("clear_wins", 0, 0, 0, 0);
        tick(); tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
